// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out word transmitter.
// Accepts an N-bit word on a valid/ready handshake and sends it LSB-first.
// Each bit is held for DIV clock cycles. A one-cycle sen strobe marks the
// last cycle of each bit period. A one-cycle frame_done pulse follows the
// final bit. sdo/sen drive a right-shifting, MSB-input SIPO stage directly.
module piso_tx #(
   parameter int N   = 4,
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] din,
   input  logic         load_valid,
   output logic         load_ready,
   output logic         sdo,
   output logic         sen,
   output logic         frame_done,
   output logic         busy
);

   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   // With DIV=1, every bit period is a single strobed cycle.
   localparam logic SEN_FIRST = (DIV == 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [N-1:0]    shreg, shreg_n;
   logic [BW-1:0]   bit_cnt, bit_cnt_n;
   logic [DW-1:0]   div_cnt, div_cnt_n;
   logic            sdo_n, sen_n, frame_done_n;
   logic            accept;

   assign load_ready = (state == IDLE) && !rst;
   assign busy       = (state != IDLE);
   assign accept     = load_valid && load_ready;

   // Next-state and next-output logic for the whole transmitter.
   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_n      = state;
      shreg_n      = shreg;
      bit_cnt_n    = bit_cnt;
      div_cnt_n    = div_cnt;
      sdo_n        = sdo;
      sen_n        = 1'b0;
      frame_done_n = 1'b0;

      case (state)
         IDLE: begin
            sdo_n = 1'b0;
            if (accept) begin
               state_n   = SHIFT;
               shreg_n   = din;
               bit_cnt_n = '0;
               div_cnt_n = '0;
               sdo_n     = din[0];
               sen_n     = SEN_FIRST;
            end
         end

         SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               // Strobe cycle: the receiver captures sdo at this edge.
               if (bit_cnt == BIT_LAST) begin
                  state_n      = LATCH;
                  sdo_n        = 1'b0;
                  frame_done_n = 1'b1;
               end else begin
                  shreg_n   = shreg >> 1;
                  sdo_n     = shreg[1];
                  bit_cnt_n = bit_cnt + BW'(1);
                  div_cnt_n = '0;
                  sen_n     = SEN_FIRST;
               end
            end else begin
               // Look ahead one count so that sen is registered yet still
               // aligned with divider == DIV-1.
               div_cnt_n = div_cnt + DW'(1);
               sen_n     = ((div_cnt + DW'(1)) == DIV_LAST);
            end
         end

         LATCH: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
            sdo_n   = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset is synchronous and aborts any frame.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         sdo        <= 1'b0;
         sen        <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_cnt    <= bit_cnt_n;
         div_cnt    <= div_cnt_n;
         sdo        <= sdo_n;
         sen        <= sen_n;
         frame_done <= frame_done_n;
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx.
// Three instances cover (N,DIV) = (4,1), (4,3) and (8,2).
// A frame-timing reference model predicts every output in every cycle.
// Accepted words go into a per-instance queue. A monitor pops the queue on
// frame_done and compares the word against a SIPO fed by sdo/sen.
module tb_piso_tx;

   localparam int NI = 3;
   localparam int NN [NI] = '{4, 4, 8};
   localparam int DD [NI] = '{1, 3, 2};

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din_a [NI];
   logic       lv_a  [NI];
   logic       lr_a  [NI];
   logic       sdo_a [NI];
   logic       sen_a [NI];
   logic       fd_a  [NI];
   logic       busy_a[NI];

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles since acceptance (0 means idle).
   int ph    [NI];
   int mword [NI];
   // Scoreboard state.
   int exp_q   [NI][$];
   int sipo    [NI];
   int sen_cnt [NI];

   always #5 clk = ~clk;

   piso_tx #(.N(4), .DIV(1)) u0 (
      .clk(clk), .rst(rst), .din(din_a[0][3:0]), .load_valid(lv_a[0]),
      .load_ready(lr_a[0]), .sdo(sdo_a[0]), .sen(sen_a[0]),
      .frame_done(fd_a[0]), .busy(busy_a[0]));

   piso_tx #(.N(4), .DIV(3)) u1 (
      .clk(clk), .rst(rst), .din(din_a[1][3:0]), .load_valid(lv_a[1]),
      .load_ready(lr_a[1]), .sdo(sdo_a[1]), .sen(sen_a[1]),
      .frame_done(fd_a[1]), .busy(busy_a[1]));

   piso_tx #(.N(8), .DIV(2)) u2 (
      .clk(clk), .rst(rst), .din(din_a[2]), .load_valid(lv_a[2]),
      .load_ready(lr_a[2]), .sdo(sdo_a[2]), .sen(sen_a[2]),
      .frame_done(fd_a[2]), .busy(busy_a[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: acceptance and frame phase, advanced at each rising edge.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            ph[i] = 0;
         end else if (ph[i] == 0) begin
            if (lv_a[i]) begin
               ph[i]    = 1;
               mword[i] = int'(din_a[i]) & ((1 << NN[i]) - 1);
               exp_q[i].push_back(mword[i]);
            end
         end else if (ph[i] == NN[i] * DD[i] + 1) begin
            ph[i] = 0;
         end else begin
            ph[i] = ph[i] + 1;
         end
      end
   end

   // Monitor: compare outputs against the model mid-cycle, feed the SIPO, and score frames.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int c, t;
         logic [4:0] e, a;
         c = ph[i];
         t = NN[i] * DD[i];
         e[0] = (c >= 1 && c <= t) ? mword[i][(c - 1) / DD[i]] : 1'b0;
         e[1] = (c >= 1 && c <= t && (c % DD[i]) == 0);
         e[2] = (c == t + 1);
         e[3] = (c >= 1 && c <= t + 1);
         e[4] = (c == 0) && !rst;
         a = {lr_a[i], busy_a[i], fd_a[i], sen_a[i], sdo_a[i]};
         check($sformatf("u%0d_outputs_phase%0d", i, c), 32'(a), 32'(e));

         if (rst) begin
            sen_cnt[i] = 0;
            exp_q[i].delete();
         end else begin
            if (sen_a[i]) begin
               sen_cnt[i] = sen_cnt[i] + 1;
               sipo[i] = (sipo[i] >> 1) | (int'(sdo_a[i]) << (NN[i] - 1));
            end
            if (fd_a[i]) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("u%0d_unexpected_frame_done", i), 32'd1, 32'd0);
               end else begin
                  int w;
                  w = exp_q[i].pop_front();
                  check($sformatf("u%0d_sipo_word", i), 32'(sipo[i]), 32'(w));
                  check($sformatf("u%0d_sen_per_frame", i), 32'(sen_cnt[i]), 32'(NN[i]));
               end
               sen_cnt[i] = 0;
            end
         end
      end
   end

   // Offer a word and hold load_valid until it is taken, then scramble din.
   task automatic send(input int i, input logic [7:0] w);
      int t;
      t = 0;
      din_a[i] = w;
      lv_a[i]  = 1'b1;
      while (1) begin
         @(negedge clk);
         if (lr_a[i]) break;
         t++;
         if (t > 200) begin
            check($sformatf("u%0d_send_timeout", i), 32'd0, 32'd1);
            lv_a[i] = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      lv_a[i]  = 1'b0;
      din_a[i] = 8'($urandom);
   endtask

   // Wait for load_ready while load_valid stays high.
   task automatic wait_ready(input int i);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!lr_a[i] && t < 200);
      check($sformatf("u%0d_ready_timeout", i), 32'(lr_a[i]), 32'd1);
   endtask

   // Wait until every instance has finished its frames.
   task automatic wait_idle();
      int t;
      bit idle;
      t = 0;
      do begin
         @(negedge clk);
         t++;
         idle = 1'b1;
         for (int i = 0; i < NI; i++)
            if (ph[i] != 0 || exp_q[i].size() != 0) idle = 1'b0;
      end while (!idle && t < 300);
      check("idle_timeout", 32'(idle), 32'd1);
   endtask

   // Random traffic on one instance with random gaps between offers.
   task automatic random_traffic(input int i, input int words);
      for (int k = 0; k < words; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(i, 8'($urandom));
      end
   endtask

   // Stimulus: directed cases first, then randomized words.
   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         lv_a[i]  = 1'b0;
         din_a[i] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      // load_valid during reset must not be accepted.
      for (int i = 0; i < NI; i++) begin
         lv_a[i]  = 1'b1;
         din_a[i] = 8'hFF;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) lv_a[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single words: 1011 with DIV=1, 0110 with DIV=3.
      fork
         send(0, 8'b1011);
         send(1, 8'b0110);
         send(2, 8'hA5);
      join
      wait_idle();

      // load_valid held high: 4'hA then 4'h5, back to back.
      din_a[0] = 8'h0A;
      lv_a[0]  = 1'b1;
      wait_ready(0);
      @(posedge clk);
      #1;
      din_a[0] = 8'h05;
      wait_ready(0);
      @(posedge clk);
      #1;
      lv_a[0] = 1'b0;
      wait_idle();

      // Reset pulsed in cycle 2 of a frame, then a clean 1001.
      send(0, 8'h0C);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(0, 8'b1001);
      wait_idle();

      // Randomized words on all instances concurrently.
      fork
         random_traffic(0, 40);
         random_traffic(1, 30);
         random_traffic(2, 120);
      join
      wait_idle();

      for (int i = 0; i < NI; i++)
         check($sformatf("u%0d_pending_words", i), 32'(exp_q[i].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute bound on run time.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out word transmitter: accepts an N-bit word through a valid/ready handshake and shifts it out LSB-first, one bit per DIV clock cycles. Each bit comes with a one-cycle sample strobe, and a frame-done pulse follows the last bit. It is the transmit end of the design's serial word link. Its `sdo`/`sen` pair drives a right-shifting, MSB-input SIPO stage directly (d=`sdo`, en=`sen`), which holds `din` after N strobes.

## Interface
- `N`, default 4: word width, legal range ≥ 2.
- `DIV`, default 1: clock cycles per bit, legal range ≥ 1.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `din` input N: word to transmit; sampled only on handshake acceptance.
- `load_valid` input 1: producer has a word on `din`.
- `load_ready` output 1: transmitter can accept a word.
- `sdo` output 1: serial data, registered.
- `sen` output 1: bit strobe, registered; the receiver samples `sdo` on the edge that ends a cycle where `sen`=1.
- `frame_done` output 1: one-cycle pulse after the last bit, registered.
- `busy` output 1: high in SHIFT and LATCH.

## Operation
- States:
  - IDLE: `sdo`=0, `sen`=0, `load_ready`=1.
  - SHIFT: bits in flight.
  - LATCH: one cycle, `frame_done`=1.
- `load_ready` = (state==IDLE) && !`rst`. It is combinational from the state register and is 0 in SHIFT and LATCH.
- Acceptance is `load_valid` && `load_ready` at a rising edge. On acceptance:
  - `din` is copied into the shift register.
  - The bit counter and the divider counter are cleared.
  - State goes to SHIFT.
  - `sdo` takes `din[0]`.
- While not accepting, `load_valid` is ignored; `din` may change freely after acceptance.
- SHIFT:
  - The divider counts 0..DIV-1.
  - `sen`=1 exactly in the cycle where divider==DIV-1. With DIV=1, `sen` is 1 for every SHIFT cycle.
  - At the edge ending a `sen` cycle:
    - If bit counter < N-1: the shift register shifts right by one, `sdo` takes the next bit, bit counter increments, divider clears.
    - If bit counter == N-1: state goes to LATCH, `sdo`=0.
- `sdo` is constant for the whole DIV-cycle period of each bit.
- LATCH: `frame_done`=1 and `sen`=0 for exactly one cycle, then IDLE.
- Bit order is LSB-first: bit k is presented in bit period k, for k = 0..N-1.
- Counter widths:
  - Bit counter: clog2(N) bits, minimum 1.
  - Divider: clog2(DIV) bits, minimum 1.
  - Neither counter wraps beyond its terminal value.

## Timing
- Reset (asserted at an edge):
  - At the next cycle: state IDLE, `sdo`=0, `sen`=0, `frame_done`=0, `busy`=0, counters 0, shift register 0.
  - While `rst`=1, `load_ready`=0.
- Reset mid-frame aborts at once. No `frame_done` is issued, and the partial word is discarded.
- `rst` and `load_valid` asserted in the same cycle: reset wins and the word is not accepted.
- Latency, with acceptance at edge E0:
  - First `sdo` bit is valid in cycle 1 after E0.
  - First `sen` is in cycle DIV.
  - The k-th `sen` (k = 1..N) is in cycle k·DIV.
  - `frame_done` is in cycle N·DIV+1.
  - IDLE (`load_ready`=1) resumes in cycle N·DIV+2.
- Throughput: one word per N·DIV+2 cycles when `load_valid` is held high continuously. Back-to-back acceptance is impossible during LATCH.
- `busy` is high from cycle 1 through cycle N·DIV+1 inclusive.
- Exactly N `sen` pulses occur per accepted word, never more and never fewer.

## Test plan
- Case N=4, DIV=1, `din`=4'b1011 with a one-cycle `load_valid`:
  - `sdo`=1,1,0,1 in cycles 1–4 with `sen`=1 in each.
  - `frame_done`=1 in cycle 5; `load_ready`=1 in cycle 6.
  - A SIPO model fed by `sdo`/`sen` holds 4'b1011.
- Case N=4, DIV=3, `din`=4'b0110:
  - Each bit is held for 3 cycles; `sen` is high only in cycles 3, 6, 9 and 12.
  - `frame_done` is in cycle 13.
  - The SIPO model holds 4'b0110.
- Case `load_valid` held high, `din`=4'hA then 4'h5, N=4, DIV=1:
  - Acceptances occur 6 cycles apart.
  - Serial stream is 0,1,0,1,(gap 2),1,0,1,0.
  - Exactly two `frame_done` pulses.
- Case `rst` pulsed in cycle 2 of a frame, N=4, DIV=1:
  - Next cycle `sdo`=0, `sen`=0, `busy`=0; no `frame_done`.
  - `load_ready`=1 once `rst` falls.
  - A following word 4'b1001 transmits correctly.
- Case `load_valid`=1 with `rst`=1 in the same cycle: no acceptance, no `sen` pulses, and `load_ready` stays 0 until `rst` drops.
- Case N=8, DIV=2, random words (≥100):
  - SIPO model output equals `din` at every `frame_done`.
  - `sen` count per frame is 8.
